wb_arb5: RTL and testbench
==========================

Name: wb_arb5

Overview:
- Five-requester round-robin arbiter for the shared Wishbone master path.
- Sits directly upstream of the 5:1 32-bit output mixer and drives that mixer's one-hot grant input.
- Grant is held for the whole of an owner's request.
- A hold timeout forces handover when other requesters are waiting.
- A one-cycle dead gap separates grants so the downstream registered select settles cleanly.

Parameters:
- MAX_HOLD, 256, maximum consecutive GRANT cycles for one owner while others request; 0 disables timeout; legal range 0..65535.

Ports:
- wb_clk_i  input  1  the block's single clock; all state changes on the rising edge.
- wb_rst_i  input  1  asynchronous, active-low reset.
- req  input  5  request per master; req[i] high = master i wants the bus and holds it.
- gnt  output  5  registered one-hot grant; all-zero when the bus is unowned.
- gnt_id  output  3  binary index of current owner; 0 when gnt==0.
- busy  output  1  equals |gnt.
- hold_to  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (wb_rst_i low, asynchronous):
  - gnt=0, gnt_id=0, busy=0, hold_to=0.
  - state=IDLE, hold counter=0, last-owner pointer=4, so master 0 wins the first arbitration.
  - Reset asserted mid-grant clears gnt immediately, without waiting for a clock edge.
- State register: IDLE, GRANT, GAP. All outputs are registered.
- Round-robin pick: search for the first i with req[i]=1, in circular order last+1, last+2, ... wrapping 4->0. The current last owner has lowest priority.
- IDLE:
  - If req!=0 at edge N: gnt=onehot(pick), gnt_id=pick, last=pick, counter=0, state=GRANT, all visible after edge N (1-cycle latency).
  - Else stay in IDLE.
- GRANT (owner o):
  - req[o]=0 at an edge: gnt=0, state=GAP, hold_to=0 (normal release).
  - req[o]=1, MAX_HOLD!=0, counter==MAX_HOLD-1 and (req & ~onehot(o))!=0: gnt=0, state=GAP, hold_to=1 for exactly one cycle (forced release).
  - Otherwise: counter increments, saturating at 65535; gnt unchanged.
  - If no other requester is pending, the timeout never fires; the owner may hold indefinitely.
  - Owner dropping req on the same edge as the timeout condition: treated as a normal release, hold_to=0.
  - Changes on non-owner req lines never change gnt during GRANT.
- GAP:
  - gnt=0 for exactly one cycle.
  - At the next edge arbitrate exactly as in IDLE; go to GRANT if any req is pending, otherwise to IDLE.
  - Minimum bus-idle time between consecutive grants is therefore one cycle.
- A force-released owner that keeps req high competes again after the gap with lowest priority. Its grant counter restarts at 0.
- Outputs never show more than one gnt bit set. gnt_id is always consistent with gnt on the same cycle.
- Counter width: 16 bits. Comparison with MAX_HOLD-1 uses 16-bit unsigned arithmetic.

Test Plan:
1. Reset, then req=5'b00001 at cycle 3 -> gnt=00001, gnt_id=0 from cycle 4. Drop req at cycle 10 -> gnt=0 at cycle 11 (GAP), state IDLE at cycle 12.
2. req=5'b11111 held, each owner drops req 4 cycles after being granted then reasserts -> grant order 0,1,2,3,4,0, with one gnt=0 cycle between each grant.
3. MAX_HOLD=8; master 2 holds req, master 3 requests from cycle 2 of master 2's grant -> gnt drops after 8 GRANT cycles, hold_to=1 for one cycle, GAP, then gnt=01000.
4. MAX_HOLD=8; only master 1 requests for 50 cycles -> gnt=00010 throughout, hold_to never asserts.
5. MAX_HOLD=8; owner drops req on the same edge the timeout would fire -> normal release, hold_to=0.
6. Assert wb_rst_i low asynchronously mid-grant (between clock edges) -> gnt=0, busy=0 immediately. After release with req=5'b10000 -> gnt=10000 one cycle later, confirming the pointer reset to 4 did not block master 4 when it is the sole requester.

Source files
------------

// File: rtl/wb_arb5_if.sv
// Request/grant bundle between the Wishbone masters and the round-robin arbiter.
// The arbiter takes the slave side; the requesting side takes the master side.
interface wb_arb5_if;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       hold_to;

  modport slave  (input req, output gnt, output gnt_id, output busy, output hold_to);
  modport master (output req, input gnt, input gnt_id, input busy, input hold_to);
endinterface

// File: rtl/wb_arb5.sv
// Five-way round-robin bus arbiter with a hold timeout and a one-cycle dead gap between grants.
// state  | meaning
// IDLE   | bus unowned, arbitrate every edge
// GRANT  | one owner holds the bus, hold counter running
// GAP    | single dead cycle after release, then arbitrate
module wb_arb5 #(
  parameter int unsigned MAX_HOLD = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  wb_arb5_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  localparam bit          HOLD_EN   = (MAX_HOLD != 0);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_gnt, w_gnt_nxt;
  logic [2:0]  r_gnt_id, w_gnt_id_nxt;
  logic [2:0]  r_last, w_last_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_hold_to, w_hold_to_nxt;
  logic [2:0]  w_pick;
  logic [2:0]  w_idx;
  logic [4:0]  w_others;

  function automatic logic [2:0] f_wrap(input logic [2:0] last, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, last} + {1'b0, k};
    f_wrap = (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  // Scan from farthest to nearest so the slot right after the last owner wins.
  always_comb begin
    w_pick = 3'd0;
    w_idx  = 3'd0;
    for (int k = 5; k >= 1; k--) begin
      w_idx = f_wrap(r_last, 3'(k));
      if (bus.req[w_idx]) w_pick = w_idx;
    end
  end

  assign w_others = bus.req & ~r_gnt;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_hold_to_nxt = 1'b0;
    case (r_state)
      S_GRANT: begin
        if (!bus.req[r_gnt_id]) begin
          w_gnt_nxt    = 5'd0;
          w_gnt_id_nxt = 3'd0;
          w_state_nxt  = S_GAP;
        end else if (HOLD_EN && (r_cnt == HOLD_LAST) && (w_others != 5'd0)) begin
          w_gnt_nxt     = 5'd0;
          w_gnt_id_nxt  = 3'd0;
          w_state_nxt   = S_GAP;
          w_hold_to_nxt = 1'b1;
        end else if (r_cnt != 16'hFFFF) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        if (bus.req != 5'd0) begin
          w_gnt_nxt    = 5'd1 << w_pick;
          w_gnt_id_nxt = w_pick;
          w_last_nxt   = w_pick;
          w_cnt_nxt    = 16'd0;
          w_state_nxt  = S_GRANT;
        end else begin
          w_gnt_nxt    = 5'd0;
          w_gnt_id_nxt = 3'd0;
          w_state_nxt  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state   <= S_IDLE;
      r_gnt     <= 5'd0;
      r_gnt_id  <= 3'd0;
      r_last    <= 3'd4;
      r_cnt     <= 16'd0;
      r_hold_to <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hold_to <= w_hold_to_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = |r_gnt;
  assign bus.hold_to = r_hold_to;

endmodule

// File: tb/tb_wb_arb5.sv
// Bench for wb_arb5: a behavioural arbiter model checked every cycle, plus directed literal checks.
module tb_wb_arb5;
  localparam int MAXH = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  wb_arb5_if bus();

  wb_arb5 #(.MAX_HOLD(MAXH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 = bus free), hold length, and last owner.
  int m_owner;
  int m_cnt;
  int m_last;
  bit m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 4;
      m_to    = 0;
    end else begin
      m_to = 0;
      if (m_owner >= 0) begin
        if (!bus.req[m_owner]) begin
          m_owner = -1;
        end else if (MAXH != 0 && m_cnt == MAXH - 1 && (bus.req & ~(5'd1 << m_owner)) != 5'd0) begin
          m_owner = -1;
          m_to    = 1;
        end else if (m_cnt < 65535) begin
          m_cnt++;
        end
      end else if (bus.req != 5'd0) begin
        for (int k = 1; k <= 5; k++) begin
          if (m_owner < 0 && bus.req[(m_last + k) % 5]) m_owner = (m_last + k) % 5;
        end
        m_last = m_owner;
        m_cnt  = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] eg;
    eg = (m_owner >= 0) ? (5'd1 << m_owner) : 5'd0;
    chk("model_gnt", 32'(bus.gnt), 32'(eg));
    chk("model_gnt_id", 32'(bus.gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("model_busy", 32'(bus.busy), 32'(m_owner >= 0));
    chk("model_hold_to", 32'(bus.hold_to), 32'(m_to));
    chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req = 5'd0;
    rst_n   = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  int exp_order [6];

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_order = '{0, 1, 2, 3, 4, 0};
    bus.req = 5'd0;
    rst_n   = 1'b0;
    cyc(2);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hold_to", 32'(bus.hold_to), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // 1: single requester, grant then release through the gap
    bus.req = 5'b00001;
    cyc(1);
    chk("t1_gnt", 32'(bus.gnt), 32'b00001);
    chk("t1_id", 32'(bus.gnt_id), 32'd0);
    cyc(6);
    chk("t1_hold", 32'(bus.gnt), 32'b00001);
    bus.req = 5'd0;
    cyc(1);
    chk("t1_gap", 32'(bus.gnt), 32'd0);
    chk("t1_gap_busy", 32'(bus.busy), 32'd0);
    cyc(1);
    chk("t1_idle", 32'(bus.gnt), 32'd0);

    // 2: everyone requests, round-robin rotation with a dead cycle each handover
    do_reset();
    bus.req = 5'b11111;
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      chk("t2_order", 32'(bus.gnt), 32'(5'd1 << exp_order[i]));
      cyc(3);
      bus.req[exp_order[i]] = 1'b0;
      cyc(1);
      chk("t2_gap", 32'(bus.gnt), 32'd0);
      bus.req[exp_order[i]] = 1'b1;
      cyc(1);
    end
    bus.req = 5'd0;
    cyc(2);

    // 3: timeout handover from master 2 to master 3
    do_reset();
    bus.req = 5'b00100;
    cyc(1);
    chk("t3_gnt2", 32'(bus.gnt), 32'b00100);
    bus.req = 5'b01100;
    cyc(7);
    chk("t3_last_cycle", 32'(bus.gnt), 32'b00100);
    chk("t3_no_to_yet", 32'(bus.hold_to), 32'd0);
    cyc(1);
    chk("t3_gap", 32'(bus.gnt), 32'd0);
    chk("t3_hold_to", 32'(bus.hold_to), 32'd1);
    cyc(1);
    chk("t3_gnt3", 32'(bus.gnt), 32'b01000);
    chk("t3_id3", 32'(bus.gnt_id), 32'd3);
    chk("t3_to_pulse", 32'(bus.hold_to), 32'd0);
    bus.req = 5'd0;
    cyc(2);

    // 4: sole requester never times out
    do_reset();
    bus.req = 5'b00010;
    cyc(50);
    chk("t4_gnt", 32'(bus.gnt), 32'b00010);
    chk("t4_to", 32'(bus.hold_to), 32'd0);
    bus.req = 5'd0;
    cyc(2);

    // 5: owner drops on the timeout edge -> ordinary release
    do_reset();
    bus.req = 5'b00100;
    cyc(1);
    bus.req = 5'b01100;
    cyc(7);
    bus.req = 5'b01000;
    cyc(1);
    chk("t5_gap", 32'(bus.gnt), 32'd0);
    chk("t5_no_to", 32'(bus.hold_to), 32'd0);
    cyc(1);
    chk("t5_gnt3", 32'(bus.gnt), 32'b01000);
    bus.req = 5'd0;
    cyc(2);

    // 6: asynchronous reset mid-grant, then master 4 alone
    do_reset();
    bus.req = 5'b00001;
    cyc(2);
    chk("t6_pre", 32'(bus.gnt), 32'b00001);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(bus.gnt), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    bus.req = 5'b10000;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("t6_gnt4", 32'(bus.gnt), 32'b10000);
    chk("t6_id4", 32'(bus.gnt_id), 32'd4);
    bus.req = 5'd0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
